// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    // Control state of the memory-stage sequencer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2,
        ST_WR   = 2'd3
    } lsu_state_e;

    // Access size decoded from Funct3[1:0].
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Funct3 encodings used by the pipeline for loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bit 1 set means word regardless of bit 0; bit 2 only affects extension.
    function automatic lsu_size_e size_decode(input logic [2:0] funct3);
        lsu_size_e sz;
        if (funct3[1]) begin
            sz = SZ_WORD;
        end else if (funct3[0]) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_BYTE;
        end
        return sz;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size_decode(funct3))
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction with sign/zero extension and the
// store-lane merge used by the read-modify-write path. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] read_word_i,
    input  logic [1:0]  byte_off_i,
    input  lsu_size_e   size_i,
    input  logic        zero_ext_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the little-endian word.
    always_comb begin
        byte_sel = read_word_i[7:0];
        case (byte_off_i)
            2'd0:    byte_sel = read_word_i[7:0];
            2'd1:    byte_sel = read_word_i[15:8];
            2'd2:    byte_sel = read_word_i[23:16];
            default: byte_sel = read_word_i[31:24];
        endcase
        half_sel = byte_off_i[1] ? read_word_i[31:16] : read_word_i[15:0];
    end

    // Extend the selected lane to 32 bits.
    always_comb begin
        load_data_o = read_word_i;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{~zero_ext_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_o = {{16{~zero_ext_i & half_sel[15]}}, half_sel};
            default: load_data_o = read_word_i;
        endcase
    end

    // Overwrite only the addressed lane(s) of the old word with store data.
    always_comb begin
        merged_o = read_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (byte_off_i)
                    2'd0:    merged_o[7:0]   = store_data_i[7:0];
                    2'd1:    merged_o[15:8]  = store_data_i[7:0];
                    2'd2:    merged_o[23:16] = store_data_i[7:0];
                    default: merged_o[31:24] = store_data_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (byte_off_i[1]) begin
                    merged_o[31:16] = store_data_i[15:0];
                end else begin
                    merged_o[15:0] = store_data_i[15:0];
                end
            end
            default: merged_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end for a word-only data memory: address-to-index
// conversion, alignment check, sub-word loads and read-modify-write stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       StoreData,
    output logic              Busy,
    output logic              Done,
    output logic              Misaligned,
    output logic [31:0]       LoadData,
    output logic [31:0]       MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemWriteEnable,
    output logic              MemReadEnable,
    input  logic [31:0]       MemReadData
);

    lsu_state_e        state_q;
    logic              rd_q;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q;
    logic              done_q;
    logic              mis_q;
    logic [31:0]       load_q;
    logic [31:0]       wdata_q;

    logic [31:0]       load_d;
    logic [31:0]       merge_d;
    logic [31:0]       word_idx;
    lsu_size_e         size_q;

    assign size_q = size_decode(f3_q);

    lsu_align u_align (
        .read_word_i  (MemReadData),
        .byte_off_i   (addr_q[1:0]),
        .size_i       (size_q),
        .zero_ext_i   (f3_q[2]),
        .store_data_i (sdata_q),
        .load_data_o  (load_d),
        .merged_o     (merge_d)
    );

    // Address bits above the memory depth alias and are deliberately dropped.
    generate
        if (ADDR_W > MEM_DEPTH_LOG2 + 2) begin : g_alias
            logic addr_hi_unused;
            assign addr_hi_unused = ^addr_q[ADDR_W-1:MEM_DEPTH_LOG2+2];
        end
    endgenerate

    // Word index from the latched byte address, zero-padded to 32 bits.
    always_comb begin
        word_idx = '0;
        word_idx[MEM_DEPTH_LOG2-1:0] = addr_q[MEM_DEPTH_LOG2+1:2];
    end

    // Sequencer: accept in IDLE, read, capture response, write back.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            load_q  <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Req) begin
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        f3_q    <= Funct3;
                        addr_q  <= Address;
                        sdata_q <= StoreData;
                        if (is_misaligned(Funct3, Address[1:0])) begin
                            done_q <= 1'b1;
                            mis_q  <= 1'b1;
                        end else if (MemWrite) begin
                            if (size_decode(Funct3) == SZ_WORD) begin
                                wdata_q <= StoreData;
                                state_q <= ST_WR;
                            end else begin
                                state_q <= ST_RD;
                            end
                        end else if (MemRead) begin
                            state_q <= ST_RD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (wr_q) begin
                        wdata_q <= merge_d;
                        state_q <= ST_WR;
                    end else begin
                        if (rd_q) begin
                            load_q <= load_d;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    wdata_q <= '0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side strobes come only from registered state; the write strobe
    // is also gated by Reset so a reset edge can never commit a write.
    assign Busy           = (state_q != ST_IDLE);
    assign MemReadEnable  = (state_q == ST_RD);
    assign MemWriteEnable = (state_q == ST_WR) && Reset;
    assign MemAddress     = (state_q == ST_IDLE) ? 32'h0 : word_idx;
    assign MemWriteData   = wdata_q;
    assign Done           = done_q;
    assign Misaligned     = mis_q;
    assign LoadData       = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with an attached word memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        Req;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic        Busy;
    logic        Done;
    logic        Misaligned;
    logic [31:0] LoadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEnable;
    logic        MemReadEnable;
    logic [31:0] MemReadData;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_load;

    int n_vec;
    int n_err;

    load_store_unit #(.ADDR_W(32), .MEM_DEPTH_LOG2(10)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Req            (Req),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .Funct3         (Funct3),
        .Address        (Address),
        .StoreData      (StoreData),
        .Busy           (Busy),
        .Done           (Done),
        .Misaligned     (Misaligned),
        .LoadData       (LoadData),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .MemWriteEnable (MemWriteEnable),
        .MemReadEnable  (MemReadEnable),
        .MemReadData    (MemReadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Data memory: registered read, write on WriteEnable.
    always @(posedge Clock) begin
        if (MemReadEnable) MemReadData <= tb_mem[MemAddress[9:0]];
        if (MemWriteEnable) tb_mem[MemAddress[9:0]] <= MemWriteData;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int ref_bytes(input logic [2:0] f3);
        int n;
        if (f3[1]) n = 4;
        else if (f3[0]) n = 2;
        else n = 1;
        return n;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
        int nb;
        logic [31:0] mask;
        logic [31:0] v;
        nb = ref_bytes(f3);
        if (nb == 4) return word;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = (word >> (8 * off)) & mask;
        if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] sd,
                                              input logic [2:0] f3, input logic [1:0] off);
        int nb;
        logic [31:0] mask;
        nb = ref_bytes(f3);
        if (nb == 4) return sd;
        mask = ((32'h1 << (8 * nb)) - 32'h1) << (8 * off);
        return (old & ~mask) | ((sd << (8 * off)) & mask);
    endfunction

    // One request: drive, accept, watch every cycle up to Done, compare.
    task automatic op(input logic r, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd);
        int nb;
        logic mis;
        int exp_lat;
        int idx;
        logic [31:0] exp_w;
        int lat;
        int we_n;
        int re_n;
        bit done_seen;
        nb  = ref_bytes(f3);
        mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
        idx = int'(a[11:2]);
        if (mis) exp_lat = 1;
        else if (w) exp_lat = (nb == 4) ? 2 : 4;
        else if (r) exp_lat = 3;
        else exp_lat = 1;
        exp_w = (w && !mis) ? ref_store(ref_mem[idx], sd, f3, a[1:0]) : 32'h0;

        Req = 1'b1; MemRead = r; MemWrite = w; Funct3 = f3; Address = a; StoreData = sd;
        @(posedge Clock);
        #1;
        Req = 1'b0;
        lat = 0; we_n = 0; re_n = 0; done_seen = 0;
        while (!done_seen && lat < 12) begin
            @(negedge Clock);
            lat++;
            if (lat == 1) check_eq("busy_first", 32'(Busy), 32'(exp_lat > 1));
            if (MemReadEnable) begin
                re_n++;
                check_eq("rd_addr", MemAddress, 32'(idx));
            end
            if (MemWriteEnable) begin
                we_n++;
                check_eq("wr_addr", MemAddress, 32'(idx));
                check_eq("wr_data", MemWriteData, exp_w);
            end
            if (Done) begin
                done_seen = 1;
            end else if (Busy) begin
                Req       = 1'($urandom_range(0, 1));
                MemRead   = 1'($urandom_range(0, 1));
                MemWrite  = 1'($urandom_range(0, 1));
                Funct3    = 3'($urandom_range(0, 7));
                Address   = $urandom;
                StoreData = $urandom;
            end
        end
        Req = 1'b0;
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("misaligned", 32'(Misaligned), 32'(mis));
        if (r && !w && !mis) exp_load = ref_load(ref_mem[idx], f3, a[1:0]);
        check_eq("load_data", LoadData, exp_load);
        check_eq("we_cycles", 32'(we_n), 32'((w && !mis) ? 1 : 0));
        check_eq("re_cycles", 32'(re_n), 32'((!mis && (r || w) && !(w && nb == 4)) ? 1 : 0));
        if (w && !mis) ref_mem[idx] = exp_w;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},   32'(Busy), 32'h0);
        check_eq({tag, "_done"},   32'(Done), 32'h0);
        check_eq({tag, "_mis"},    32'(Misaligned), 32'h0);
        check_eq({tag, "_ld"},     LoadData, 32'h0);
        check_eq({tag, "_we"},     32'(MemWriteEnable), 32'h0);
        check_eq({tag, "_re"},     32'(MemReadEnable), 32'h0);
        check_eq({tag, "_wdata"},  MemWriteData, 32'h0);
        check_eq({tag, "_maddr"},  MemAddress, 32'h0);
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] a;
        int steps;
        n_vec = 0; n_err = 0; exp_load = 32'h0;
        Reset = 1'b0; Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b000; Address = 32'h0; StoreData = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 32'(i);
            ref_mem[i] = 32'(i);
        end
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b1;
        @(negedge Clock);

        op(1'b1, 1'b0, F3_W, 32'h14, 32'h0);
        check_eq("plan_lw14", LoadData, 32'h0000_0005);

        op(1'b0, 1'b1, F3_W, 32'h20, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, F3_B, 32'h23, 32'h0);
        check_eq("plan_lb", LoadData, 32'hFFFF_FFDE);
        op(1'b1, 1'b0, F3_BU, 32'h23, 32'h0);
        check_eq("plan_lbu", LoadData, 32'h0000_00DE);
        op(1'b1, 1'b0, F3_H, 32'h22, 32'h0);
        check_eq("plan_lh", LoadData, 32'hFFFF_DEAD);
        op(1'b1, 1'b0, F3_HU, 32'h20, 32'h0);
        check_eq("plan_lhu", LoadData, 32'h0000_BEEF);

        op(1'b0, 1'b1, F3_B, 32'h21, 32'h1234_567F);
        op(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
        check_eq("plan_sb", LoadData, 32'hDEAD_7FEF);
        op(1'b0, 1'b1, F3_H, 32'h22, 32'hAAAA_1111);
        op(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
        check_eq("plan_sh", LoadData, 32'h1111_7FEF);

        op(1'b1, 1'b0, F3_W, 32'h06, 32'h0);
        check_eq("mis_lw_hold", LoadData, 32'h1111_7FEF);
        op(1'b0, 1'b1, F3_H, 32'h23, 32'h5555_5555);
        check_eq("mis_sh_mem", tb_mem[8], 32'h1111_7FEF);
        op(1'b0, 1'b0, F3_W, 32'h40, 32'h0);

        op(1'b1, 1'b0, F3_W, 32'hFFFF_F020, 32'h0);
        check_eq("alias_lw", LoadData, 32'h1111_7FEF);

        // Reset asserted during the write cycle of a halfword RMW.
        saved = tb_mem[8];
        Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = F3_H;
        Address = 32'h20; StoreData = 32'h0000_9999;
        @(posedge Clock);
        #1;
        Req = 1'b0;
        steps = 0;
        while (!MemWriteEnable && steps < 10) begin
            @(negedge Clock);
            steps++;
        end
        check_eq("abort_wr_cycle", 32'(steps), 32'd3);
        Reset = 1'b0;
        @(negedge Clock);
        check_all_zero("abort");
        Reset = 1'b1;
        exp_load = 32'h0;
        @(negedge Clock);
        check_eq("abort_no_done", 32'(Done), 32'h0);
        check_eq("abort_mem", tb_mem[8], saved);

        // Back-to-back loads: each op drives its Req in the previous Done cycle.
        op(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
        op(1'b1, 1'b0, F3_W, 32'h24, 32'h0);
        check_eq("b2b_lw", LoadData, 32'h0000_0009);

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:6] = 6'h0;
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), a, $urandom);
        end

        for (int i = 0; i < 16; i++) begin
            check_eq("final_mem", tb_mem[i], ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
